// File: rtl/pdm_mic_rx_if.sv
// Sample stream between the PDM receiver and its audio consumer:
// an 8-bit unsigned sample with valid/ready handshake plus a sticky overflow flag.
interface pdm_mic_rx_if;
   logic [7:0] sample;
   logic       sample_valid;
   logic       sample_ready;
   logic       overflow;

   modport master (
      output sample,
      output sample_valid,
      output overflow,
      input  sample_ready
   );

   modport slave (
      input  sample,
      input  sample_valid,
      input  overflow,
      output sample_ready
   );
endinterface

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver. Generates mic_clk, takes one synchronised PDM bit per
// mic_clk period on its falling edge, counts ones over DECIMATION bits and presents
// the scaled, saturated 8-bit unsigned result on a valid/ready stream. A result that
// arrives while the previous one is still pending overwrites it and sets a sticky
// overflow flag.
// Optional feature macro: PDM_MIC_RX_SMOOTH_EN -- when defined, each output is the
// floor-average of the current and previous window results.
module pdm_mic_rx #(
   parameter int HALF_PERIOD = 25,
   parameter int DECIMATION  = 256
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   output logic         mic_clk,
   output logic         mic_lrsel,
   input  logic         mic_data,
   pdm_mic_rx_if.master audio
);
   localparam int               BIT_W    = $clog2(DECIMATION);
   localparam int               SCALE    = 256 / DECIMATION;
   localparam logic [7:0]       HP_LAST  = 8'(HALF_PERIOD - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIMATION - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [7:0]       hp_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [8:0]       ones;
   logic [8:0]       ones_total;
   logic             hp_wrap;
   logic             take_bit;
   logic             win_vld_p0;
   logic [7:0]       result_p0;
   logic [7:0]       load_val;
   logic             transfer;

   // Window result: ones count scaled to the 8-bit range; a full window of ones
   // scales to 256, which clips to 255.
   function automatic logic [7:0] sat_result(input logic [8:0] n);
      logic [12:0] scaled;
      scaled = 13'(n) * 13'(SCALE);
      return (scaled > 13'd255) ? 8'hFF : scaled[7:0];
   endfunction

   assign mic_lrsel  = 1'b0;
   assign hp_wrap    = (hp_cnt == HP_LAST);
   // mic_clk is high while the counter wraps, so this is the 1->0 toggle edge
   assign take_bit   = enable && hp_wrap && mic_clk;
   assign win_vld_p0 = take_bit && (bit_cnt == BIT_LAST);
   // The completing bit is folded in directly so no bit is lost at the boundary
   assign ones_total = ones + {8'd0, sync_p1};
   assign result_p0  = sat_result(ones_total);
   assign transfer   = audio.sample_valid && audio.sample_ready;

   // Two-flop synchroniser for the asynchronous PDM bitstream (stage p0 -> p1)
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= mic_data;
         sync_p1 <= sync_p0;
      end
   end

   // Half-period counter and mic_clk generation; idle low while disabled
   always_ff @(posedge clk) begin
      if (!reset_n || !enable) begin
         hp_cnt  <= 8'd0;
         mic_clk <= 1'b0;
      end else if (hp_wrap) begin
         hp_cnt  <= 8'd0;
         mic_clk <= ~mic_clk;
      end else begin
         hp_cnt  <= hp_cnt + 8'd1;
      end
   end

   // Bit and ones counters; a window boundary restarts both, disable drops the partial window
   always_ff @(posedge clk) begin
      if (!reset_n || !enable) begin
         bit_cnt <= '0;
         ones    <= 9'd0;
      end else if (take_bit) begin
         if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            ones    <= 9'd0;
         end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            ones    <= ones_total;
         end
      end
   end

`ifdef PDM_MIC_RX_SMOOTH_EN
   logic [7:0] prev_p1;

   function automatic logic [7:0] smooth_avg(input logic [7:0] cur, input logic [7:0] prev);
      logic [8:0] sum;
      sum = {1'b0, cur} + {1'b0, prev};
      return sum[8:1];
   endfunction

   // Previous window result; zero after reset or disable so the first output averages with 0
   always_ff @(posedge clk) begin
      if (!reset_n || !enable) begin
         prev_p1 <= 8'd0;
      end else if (win_vld_p0) begin
         prev_p1 <= result_p0;
      end
   end

   assign load_val = smooth_avg(result_p0, prev_p1);
`else
   assign load_val = result_p0;
`endif

   // Output stage p1: load new result, retire on transfer, flag overwritten samples
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         audio.sample       <= 8'h00;
         audio.sample_valid <= 1'b0;
         audio.overflow     <= 1'b0;
      end else if (win_vld_p0) begin
         audio.sample       <= load_val;
         audio.sample_valid <= 1'b1;
         if (audio.sample_valid && !audio.sample_ready) begin
            audio.overflow <= 1'b1;
         end
      end else if (transfer) begin
         audio.sample_valid <= 1'b0;
      end
   end
endmodule

// File: doc/pdm_mic_rx.md
PDM_MIC_RX -- requirements
Module: pdm_mic_rx

Interface
REQ-001 Parameter HALF_PERIOD, default 25: clk cycles per mic_clk half-period; legal range 2..255.
REQ-002 Parameter DECIMATION, default 256: PDM bits per output sample; power of two, 16..256.
REQ-003 clk  input  1  system clock (100 MHz); single clock domain.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  high = run capture; low = idle.
REQ-006 mic_clk  output  1  PDM microphone clock.
REQ-007 mic_lrsel  output  1  channel select, tied 0.
REQ-008 mic_data  input  1  PDM bitstream, asynchronous to clk.
REQ-009 sample  output  8  decimated unsigned audio sample; same format the PWM audio output consumes.
REQ-010 sample_valid  output  1  sample holds an unconsumed value.
REQ-011 sample_ready  input  1  consumer accepts sample when high with sample_valid.
REQ-012 overflow  output  1  sticky: a sample was dropped.

Function
REQ-013 mic_data SHALL pass through a 2-flop synchroniser before any use.
REQ-014 A half-period counter SHALL toggle mic_clk every HALF_PERIOD clk cycles while enable=1, giving a 50% duty mic_clk of period 2*HALF_PERIOD (2 MHz at default).
REQ-015 The synchronised bit SHALL be taken on the clk edge at which mic_clk toggles 1->0, one bit per mic_clk period.
REQ-016 A ones counter (9 bits) SHALL accumulate taken bits; a bit counter SHALL count bits 0..DECIMATION-1 and wrap to 0.
REQ-017 On the bit completing a window (the last bit included), the window result SHALL be N*(256/DECIMATION), saturated to 255, where N is the window's ones count.
REQ-018 On that same edge, ones counter SHALL restart at 0, so consecutive windows do not overlap and lose no bits.
REQ-019 The window result SHALL reach sample with sample_valid=1 one clk after the completing bit (latency 1).
REQ-020 A transfer occurs when sample_valid && sample_ready; sample_valid SHALL fall the next cycle unless a new result loads that same cycle.
REQ-021 A new result while sample_valid=1 and no transfer in that cycle SHALL overwrite sample, keep sample_valid=1 and set overflow.
REQ-022 A new result simultaneous with a transfer SHALL load normally, with no overflow.
REQ-023 overflow SHALL stay set until reset.
REQ-024 sample SHALL hold its value while sample_valid=1 and no new result loads.
REQ-025 enable=0 SHALL drive mic_clk=0 and clear half-period, bit and ones counters; any partial window is discarded; sample, sample_valid and overflow are retained.
REQ-026 On re-enable, the first window SHALL begin at the first mic_clk period.
REQ-027 With default parameters, one sample SHALL be produced every 12800 clk cycles (7.8125 kHz).

Reset
REQ-028 reset_n=0 at a clk edge SHALL force mic_clk=0, mic_lrsel=0, sample=8'h00, sample_valid=0 and overflow=0, and SHALL clear all counters and synchroniser flops.
REQ-029 Reset mid-window SHALL discard the partial window; the first post-reset sample reflects only post-reset bits.

Configuration
REQ-030 Macro PDM_MIC_RX_SMOOTH_EN, when defined, SHALL output floor((R_n + R_(n-1))/2), where R is the window result of REQ-017; the previous-result register is reset to 0 and also cleared by enable=0.
REQ-031 With PDM_MIC_RX_SMOOTH_EN defined, the first sample after reset or re-enable SHALL use R_(n-1)=0.
REQ-032 Without PDM_MIC_RX_SMOOTH_EN, sample SHALL equal R_n directly and no previous-result register SHALL exist.

Verification
REQ-033 Defaults, mic_data=1 constant, sample_ready=1 -> sample=8'hFF every 12800 cycles, overflow=0.
REQ-034 mic_data alternating 1,0 per mic_clk period -> sample=8'h80; constant 0 -> sample=8'h00.
REQ-035 DECIMATION=16, mic_data=1 for 4 of every 16 bits -> sample=8'h40.
REQ-036 sample_ready=0 across two windows -> sample_valid stays 1, sample = second result, overflow=1; ready pulsed at result edge -> no overflow.
REQ-037 reset_n low for 3 cycles mid-window, then all-ones -> first sample=8'hFF exactly DECIMATION mic_clk periods after release; all outputs 0 during reset.
REQ-038 PDM_MIC_RX_SMOOTH_EN defined, all-ones from reset -> samples 8'h7F then 8'hFF.
